// File: rtl/hazard_control_unit_if.sv
// rtl/hazard_control_unit_if.sv - pipeline-side signal bundle for the hazard control unit
interface hazard_control_unit_if #(
   parameter int CNT_W = 16
);
   logic [4:0]       id_rs1;
   logic [4:0]       id_rs2;
   logic             id_use_rs1;
   logic             id_use_rs2;
   logic [4:0]       ex_rd;
   logic             ex_memread;
   logic             branch_taken;
   logic             mem_busy;
   logic             pc_write;
   logic             ifid_write;
   logic             idex_write;
   logic             exmem_write;
   logic             ifid_flush;
   logic             idex_bubble;
   logic [CNT_W-1:0] stall_cycles;
   logic [CNT_W-1:0] flush_count;
   logic             mem_timeout;
   logic [1:0]       hz_state;

   modport master (
      output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memread,
             branch_taken, mem_busy,
      input  pc_write, ifid_write, idex_write, exmem_write, ifid_flush,
             idex_bubble, stall_cycles, flush_count, mem_timeout, hz_state
   );

   modport slave (
      input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memread,
             branch_taken, mem_busy,
      output pc_write, ifid_write, idex_write, exmem_write, ifid_flush,
             idex_bubble, stall_cycles, flush_count, mem_timeout, hz_state
   );
endinterface

// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - load-use stall, branch flush and memory freeze control
module hazard_control_unit #(
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 255
) (
   input logic                   clk,
   input logic                   rst,
   hazard_control_unit_if.slave  bus
);
   localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   localparam logic [1:0] ST_RUN      = 2'd0;
   localparam logic [1:0] ST_MEM_WAIT = 2'd1;
   localparam logic [1:0] ST_ERROR    = 2'd2;

   logic [1:0]        state;
   logic              flush_pending;
   logic [WAIT_W-1:0] wait_cnt;
   logic [CNT_W-1:0]  stall_cnt;
   logic [CNT_W-1:0]  flush_cnt;
   logic              timeout_flag;

   logic load_use;
   logic freeze;
   logic flush;
   logic stall;
   logic pc_en;

   always_comb begin
      load_use = bus.ex_memread && (bus.ex_rd != 5'd0) &&
                 ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                  (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd)));
      // Reset forces the default enables regardless of the (possibly unknown) state.
      freeze = !rst && ((state == ST_ERROR) || bus.mem_busy);
      flush  = !rst && !freeze && (bus.branch_taken || flush_pending);
      stall  = !rst && !freeze && !flush && load_use;
      pc_en  = !(freeze || stall);
   end

   assign bus.pc_write     = pc_en;
   assign bus.ifid_write   = pc_en;
   assign bus.idex_write   = !freeze;
   assign bus.exmem_write  = !freeze;
   assign bus.ifid_flush   = flush;
   assign bus.idex_bubble  = flush || stall;
   assign bus.stall_cycles = stall_cnt;
   assign bus.flush_count  = flush_cnt;
   assign bus.mem_timeout  = timeout_flag;
   assign bus.hz_state     = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_RUN;
         flush_pending <= 1'b0;
         wait_cnt      <= '0;
         stall_cnt     <= '0;
         flush_cnt     <= '0;
         timeout_flag  <= 1'b0;
      end else begin
         case (state)
            ST_RUN: begin
               if (bus.mem_busy) begin
                  state    <= ST_MEM_WAIT;
                  wait_cnt <= '0;
               end
            end
            ST_MEM_WAIT: begin
               if (!bus.mem_busy) begin
                  state <= ST_RUN;
               end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
                  state        <= ST_ERROR;
                  timeout_flag <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               end
            end
            ST_ERROR: state <= ST_ERROR;
            default:  state <= ST_RUN;
         endcase

         // A branch seen while frozen is replayed on the first unfrozen cycle, once.
         if (flush) begin
            flush_pending <= 1'b0;
         end else if (freeze && bus.branch_taken) begin
            flush_pending <= 1'b1;
         end

         if (!pc_en && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
         end
         if (flush && (flush_cnt != '1)) begin
            flush_cnt <= flush_cnt + CNT_W'(1);
         end
      end
   end
endmodule

// File: tb/tb_hazard_control_unit.sv
// tb/tb_hazard_control_unit.sv - directed vector bench for hazard_control_unit
module tb_hazard_control_unit;
   localparam int CNT_W = 16;

   typedef struct {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       use1;
      logic       use2;
      logic [4:0] rd;
      logic       memread;
      logic       branch;
      logic       busy;
      logic [5:0] exp_ctrl;
   } vec_t;

   logic clk;
   logic rst;
   int   checks   = 0;
   int   failures = 0;
   vec_t vecs[13];
   int   exp_stall;
   int   exp_flush;

   hazard_control_unit_if #(.CNT_W(CNT_W)) hz ();

   hazard_control_unit #(.CNT_W(CNT_W), .TIMEOUT(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (hz.slave)
   );

   // {pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_bubble}
   logic [5:0] ctrl;
   assign ctrl = {hz.pc_write, hz.ifid_write, hz.idex_write, hz.exmem_write,
                  hz.ifid_flush, hz.idex_bubble};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic use1,
                         input logic use2, input logic [4:0] rd, input logic memread,
                         input logic branch, input logic busy);
      hz.id_rs1       = rs1;
      hz.id_rs2       = rs2;
      hz.id_use_rs1   = use1;
      hz.id_use_rs2   = use2;
      hz.ex_rd        = rd;
      hz.ex_memread   = memread;
      hz.branch_taken = branch;
      hz.mem_busy     = busy;
   endtask

   task automatic idle();
      set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      //            rs1    rs2    u1    u2    rd     mr    br    busy  expected
      vecs[0]  = '{5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 6'b111100};
      vecs[1]  = '{5'd3,  5'd0,  1'b1, 1'b0, 5'd3,  1'b1, 1'b0, 1'b0, 6'b001101};
      vecs[2]  = '{5'd0,  5'd0,  1'b1, 1'b1, 5'd0,  1'b1, 1'b0, 1'b0, 6'b111100};
      vecs[3]  = '{5'd1,  5'd7,  1'b1, 1'b1, 5'd7,  1'b1, 1'b0, 1'b0, 6'b001101};
      vecs[4]  = '{5'd1,  5'd7,  1'b1, 1'b0, 5'd7,  1'b1, 1'b0, 1'b0, 6'b111100};
      vecs[5]  = '{5'd7,  5'd7,  1'b1, 1'b1, 5'd7,  1'b0, 1'b0, 1'b0, 6'b111100};
      vecs[6]  = '{5'd4,  5'd6,  1'b1, 1'b1, 5'd5,  1'b1, 1'b0, 1'b0, 6'b111100};
      vecs[7]  = '{5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 6'b111111};
      vecs[8]  = '{5'd9,  5'd0,  1'b1, 1'b0, 5'd9,  1'b1, 1'b1, 1'b0, 6'b111111};
      vecs[9]  = '{5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 6'b000000};
      vecs[10] = '{5'd2,  5'd0,  1'b1, 1'b0, 5'd2,  1'b1, 1'b0, 1'b1, 6'b000000};
      vecs[11] = '{5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 6'b111100};
      vecs[12] = '{5'd31, 5'd0,  1'b1, 1'b0, 5'd31, 1'b1, 1'b0, 1'b0, 6'b001101};

      // Reset with hazards and freeze on the inputs: defaults must win.
      rst = 1'b1;
      set_in(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b1);
      #1 check("rst_ctrl_ignores_inputs", 32'(ctrl), 32'(6'b111100));
      tick();
      tick();
      check("rst_state", 32'(hz.hz_state), 32'd0);
      check("rst_stall", 32'(hz.stall_cycles), 32'd0);
      check("rst_flush", 32'(hz.flush_count), 32'd0);
      check("rst_timeout", 32'(hz.mem_timeout), 32'd0);
      rst = 1'b0;
      idle();

      exp_stall = 0;
      exp_flush = 0;
      for (int i = 0; i < 13; i++) begin
         set_in(vecs[i].rs1, vecs[i].rs2, vecs[i].use1, vecs[i].use2, vecs[i].rd,
                vecs[i].memread, vecs[i].branch, vecs[i].busy);
         #1 check($sformatf("vec%0d_ctrl", i), 32'(ctrl), 32'(vecs[i].exp_ctrl));
         if (vecs[i].exp_ctrl[5] == 1'b0) exp_stall++;
         if (vecs[i].exp_ctrl[1] == 1'b1) exp_flush++;
         tick();
      end
      idle();
      check("vec_stall_total", 32'(hz.stall_cycles), 32'(exp_stall));
      check("vec_flush_total", 32'(hz.flush_count), 32'(exp_flush));
      check("vec_state_run", 32'(hz.hz_state), 32'd0);

      // Single load-use, then the same pattern through x0.
      do_reset();
      set_in(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
      #1 check("lu_ctrl", 32'(ctrl), 32'(6'b001101));
      tick();
      idle();
      #1 check("lu_after_ctrl", 32'(ctrl), 32'(6'b111100));
      check("lu_stall", 32'(hz.stall_cycles), 32'd1);
      set_in(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
      #1 check("x0_ctrl", 32'(ctrl), 32'(6'b111100));
      tick();
      check("x0_stall_unchanged", 32'(hz.stall_cycles), 32'd1);

      // Four-cycle freeze.
      do_reset();
      hz.mem_busy = 1'b1;
      for (int c = 0; c < 4; c++) begin
         #1 check($sformatf("frz%0d_ctrl", c), 32'(ctrl), 32'(6'b000000));
         check($sformatf("frz%0d_state", c), 32'(hz.hz_state), (c == 0) ? 32'd0 : 32'd1);
         tick();
      end
      hz.mem_busy = 1'b0;
      #1 check("frz_release_ctrl", 32'(ctrl), 32'(6'b111100));
      check("frz_release_state", 32'(hz.hz_state), 32'd1);
      tick();
      check("frz_back_run", 32'(hz.hz_state), 32'd0);
      check("frz_stall", 32'(hz.stall_cycles), 32'd4);

      // Branch during freeze is deferred; coincident branch does not double-flush.
      do_reset();
      hz.mem_busy     = 1'b1;
      hz.branch_taken = 1'b1;
      #1 check("dfl_frozen0", 32'(ctrl), 32'(6'b000000));
      tick();
      hz.branch_taken = 1'b0;
      for (int c = 1; c < 3; c++) begin
         #1 check($sformatf("dfl_frozen%0d", c), 32'(ctrl), 32'(6'b000000));
         tick();
      end
      hz.mem_busy     = 1'b0;
      hz.branch_taken = 1'b1;
      #1 check("dfl_flush", 32'(ctrl), 32'(6'b111111));
      tick();
      hz.branch_taken = 1'b0;
      #1 check("dfl_no_second", 32'(ctrl), 32'(6'b111100));
      tick();
      check("dfl_count", 32'(hz.flush_count), 32'd1);

      // Timeout with TIMEOUT=8: entry edge plus eight counted MEM_WAIT edges.
      do_reset();
      hz.mem_busy = 1'b1;
      for (int c = 0; c < 8; c++) tick();
      check("to_still_wait", 32'(hz.hz_state), 32'd1);
      check("to_flag_clear", 32'(hz.mem_timeout), 32'd0);
      tick();
      check("to_state_error", 32'(hz.hz_state), 32'd2);
      check("to_flag_set", 32'(hz.mem_timeout), 32'd1);
      set_in(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0);
      #1 check("to_err_frozen", 32'(ctrl), 32'(6'b000000));
      tick();
      tick();
      tick();
      check("to_err_stays", 32'(hz.hz_state), 32'd2);
      check("to_err_ctrl", 32'(ctrl), 32'(6'b000000));
      rst = 1'b1;
      #1 check("to_rst_ctrl", 32'(ctrl), 32'(6'b111100));
      tick();
      rst = 1'b0;
      idle();
      check("to_rst_state", 32'(hz.hz_state), 32'd0);
      check("to_rst_flag", 32'(hz.mem_timeout), 32'd0);
      check("to_rst_stall", 32'(hz.stall_cycles), 32'd0);
      check("to_rst_flush", 32'(hz.flush_count), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/hazard_control_unit.md
HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset (clk and rst).
REQ-002 Parameters SHALL be:
- CNT_W, default 16, width of the performance counters.
- TIMEOUT, default 255, maximum number of consecutive mem_busy cycles before an error.
REQ-003 Ports SHALL be:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active high
- id_rs1, id_rs2  in  5  source registers of the instruction in ID
- id_use_rs1, id_use_rs2  in  1  the ID instruction actually reads rs1/rs2
- ex_rd  in  5  destination register of the instruction in EX
- ex_memread  in  1  the instruction in EX is a load
- branch_taken  in  1  branch or jump resolved taken in EX
- mem_busy  in  1  data memory not ready; the pipeline must freeze
- pc_write, ifid_write, idex_write, exmem_write  out  1  pipeline register enables
- ifid_flush  out  1  clear IF/ID to NOP
- idex_bubble  out  1  load NOP into ID/EX
- stall_cycles  out  CNT_W  saturating count of cycles with pc_write=0
- flush_count  out  CNT_W  saturating count of cycles with ifid_flush=1
- mem_timeout  out  1  sticky error flag
- hz_state  out  2  current state: RUN=0, MEM_WAIT=1, ERROR=2

Function
REQ-004 The FSM SHALL have three states: RUN, MEM_WAIT and ERROR.
REQ-005 A load-use hazard SHALL be defined as: ex_memread=1, ex_rd!=0, and either (id_use_rs1 and id_rs1==ex_rd) or (id_use_rs2 and id_rs2==ex_rd).
REQ-006 Control outputs SHALL be combinational from the state, the inputs and flush_pending; counters and mem_timeout SHALL be registered.
REQ-007 Default outputs (no event) SHALL be: all four write enables =1, ifid_flush=0, idex_bubble=0.
REQ-008 Priority per cycle SHALL be: ERROR > mem_busy > flush (branch_taken or flush_pending) > load-use.
REQ-009 Freeze (mem_busy=1 in RUN or MEM_WAIT) SHALL drive all write enables to 0, ifid_flush=0 and idex_bubble=0, in the same cycle, with zero latency.
REQ-010 Flush SHALL drive ifid_flush=1 and idex_bubble=1 with all write enables =1, for exactly one cycle per event.
REQ-011 Load-use SHALL drive pc_write=0, ifid_write=0, idex_bubble=1, with idex_write and exmem_write =1.
- Exactly one bubble per hazard.
- No state change.
REQ-012 RUN -> MEM_WAIT SHALL occur on a clock edge where mem_busy=1; MEM_WAIT -> RUN SHALL occur on an edge where mem_busy=0.
REQ-013 A wait counter SHALL:
- clear on entry to MEM_WAIT;
- increment on each MEM_WAIT cycle with mem_busy=1;
- on reaching TIMEOUT, set mem_timeout=1 and move to ERROR.
REQ-014 ERROR SHALL freeze the pipeline as in REQ-009 and remain until rst, regardless of inputs.
REQ-015 branch_taken=1 during freeze SHALL set flush_pending.
- The flush executes in the first cycle with mem_busy=0.
- flush_pending clears on that edge.
- A coincident branch_taken in that cycle SHALL produce no second flush.
REQ-016 stall_cycles SHALL increment on every edge where pc_write=0 (load-use, freeze, ERROR) and saturate at all-ones.
REQ-017 flush_count SHALL increment on every edge where ifid_flush=1 and saturate at all-ones.
REQ-018 Register x0 SHALL never cause a load-use stall.

Reset
REQ-019 On an rst=1 edge the block SHALL set: hz_state=RUN, flush_pending=0, wait counter=0, stall_cycles=0, flush_count=0, mem_timeout=0.
REQ-020 While rst=1, control outputs SHALL take the defaults of REQ-007 and all inputs SHALL be ignored.
REQ-021 Reset asserted mid-MEM_WAIT or in ERROR SHALL return the block to RUN on the next edge.

Verification
REQ-022 Load-use case: ex_memread=1, ex_rd=3, id_rs1=3, id_use_rs1=1 for one cycle -> pc_write=0, ifid_write=0, idex_bubble=1 that cycle; stall_cycles=1 afterwards.
REQ-023 Register x0 case: same stimulus as REQ-022 with ex_rd=0 -> default outputs; stall_cycles unchanged.
REQ-024 Freeze case: mem_busy=1 for 4 cycles -> all enables 0 for those 4 cycles; hz_state=1 from the second cycle; back to RUN after mem_busy drops; stall_cycles=4.
REQ-025 Deferred flush case: branch_taken=1 during mem_busy -> no flush while frozen; ifid_flush=1 and idex_bubble=1 in exactly one cycle after mem_busy=0; flush_count=1.
REQ-026 Timeout case: TIMEOUT=8, mem_busy held high -> mem_timeout=1 and hz_state=2; pipeline stays frozen after mem_busy drops; rst pulse restores RUN with counters 0.
REQ-027 Priority case: branch_taken=1 together with a load-use hazard -> flush outputs only (pc_write=1); stall_cycles unchanged.
